// File: rtl/dcache_port_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module   : dcache_port_arbiter_if
// Brief    : Requester, cache request and load-response bundle for the
//            data-cache port arbiter.
// Revision : 1.0  initial release
// =============================================================================
interface dcache_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_BITS   = 6
) ();
    logic                  flush;

    logic                  ld_valid;
    logic                  ld_ready;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [TAG_BITS-1:0]   ld_tag;

    logic                  st_valid;
    logic                  st_ready;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_data;

    logic                  cache_valid;
    logic                  cache_write;
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic [DATA_WIDTH-1:0] cache_wdata;
    logic                  cache_ready;
    logic                  cache_rsp_valid;
    logic [DATA_WIDTH-1:0] cache_rsp_data;

    logic                  ld_rsp_valid;
    logic [TAG_BITS-1:0]   ld_rsp_tag;
    logic [DATA_WIDTH-1:0] ld_rsp_data;

    // Arbiter side
    modport master (
        input  flush,
        input  ld_valid, ld_addr, ld_tag,
        output ld_ready,
        input  st_valid, st_addr, st_data,
        output st_ready,
        output cache_valid, cache_write, cache_addr, cache_wdata,
        input  cache_ready, cache_rsp_valid, cache_rsp_data,
        output ld_rsp_valid, ld_rsp_tag, ld_rsp_data
    );

    // Requesters and cache side
    modport slave (
        output flush,
        output ld_valid, ld_addr, ld_tag,
        input  ld_ready,
        output st_valid, st_addr, st_data,
        input  st_ready,
        input  cache_valid, cache_write, cache_addr, cache_wdata,
        output cache_ready, cache_rsp_valid, cache_rsp_data,
        input  ld_rsp_valid, ld_rsp_tag, ld_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/dcache_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : dcache_port_arbiter
// Brief    : Shares the single data-cache port between speculative loads and
//            committed stores; one transaction in flight, store priority with
//            a starvation guard, flush-killed load responses are dropped.
//            Optional grant statistics: define DCACHE_ARB_STATS_EN.
// Revision : 1.0  initial release
// =============================================================================
module dcache_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_BITS     = 6,
    parameter int STARVE_LIMIT = 3
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    dcache_port_arbiter_if.master bus
`ifdef DCACHE_ARB_STATS_EN
    ,
    output logic [31:0]           stat_ld_grants,
    output logic [31:0]           stat_st_grants,
    output logic [31:0]           stat_starve_forces
`endif
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT_RD = 2'd2
    } state_e;

    state_e                state_q,       state_d;
    logic                  cache_valid_q, cache_valid_d;
    logic                  cache_write_q, cache_write_d;
    logic [ADDR_WIDTH-1:0] cache_addr_q,  cache_addr_d;
    logic [DATA_WIDTH-1:0] cache_wdata_q, cache_wdata_d;
    logic [TAG_BITS-1:0]   tag_q,         tag_d;
    logic [CNT_W-1:0]      starve_cnt_q,  starve_cnt_d;
    logic                  kill_q,        kill_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [TAG_BITS-1:0]   rsp_tag_q,     rsp_tag_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,    rsp_data_d;

    logic w_in_idle;
    logic w_force_ld;
    logic w_st_grant;
    logic w_ld_grant;
    logic w_handshake;

    // Grants are gated by rst_n so both ready outputs read 0 while in reset.
    always_comb begin
        w_in_idle   = rst_n && (state_q == S_IDLE);
        w_force_ld  = bus.ld_valid && (starve_cnt_q == c_starve_max);
        w_st_grant  = w_in_idle && bus.st_valid && !w_force_ld;
        w_ld_grant  = w_in_idle && !w_st_grant && bus.ld_valid && !bus.flush;
        w_handshake = (state_q == S_REQ) && cache_valid_q && bus.cache_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cache_valid_q <= 1'b0;
            cache_write_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_wdata_q <= '0;
            tag_q         <= '0;
            starve_cnt_q  <= '0;
            kill_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_tag_q     <= '0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            cache_valid_q <= cache_valid_d;
            cache_write_q <= cache_write_d;
            cache_addr_q  <= cache_addr_d;
            cache_wdata_q <= cache_wdata_d;
            tag_q         <= tag_d;
            starve_cnt_q  <= starve_cnt_d;
            kill_q        <= kill_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cache_valid_d = cache_valid_q;
        cache_write_d = cache_write_q;
        cache_addr_d  = cache_addr_q;
        cache_wdata_d = cache_wdata_q;
        tag_d         = tag_q;
        starve_cnt_d  = starve_cnt_q;
        kill_d        = kill_q;
        rsp_valid_d   = 1'b0;
        rsp_tag_d     = rsp_tag_q;
        rsp_data_d    = rsp_data_q;

        case (state_q)
            S_IDLE: begin
                if (w_st_grant) begin
                    state_d       = S_REQ;
                    cache_valid_d = 1'b1;
                    cache_write_d = 1'b1;
                    cache_addr_d  = bus.st_addr;
                    cache_wdata_d = bus.st_data;
                    kill_d        = 1'b0;
                    if (!bus.ld_valid) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != c_starve_max) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (w_ld_grant) begin
                    state_d       = S_REQ;
                    cache_valid_d = 1'b1;
                    cache_write_d = 1'b0;
                    cache_addr_d  = bus.ld_addr;
                    cache_wdata_d = '0;
                    tag_d         = bus.ld_tag;
                    kill_d        = 1'b0;
                    starve_cnt_d  = '0;
                end
            end

            S_REQ: begin
                // Stores are committed; only an in-flight load can be killed.
                if (!cache_write_q && bus.flush) begin
                    kill_d = 1'b1;
                end
                if (w_handshake) begin
                    cache_valid_d = 1'b0;
                    state_d       = cache_write_q ? S_IDLE : S_WAIT_RD;
                end
            end

            S_WAIT_RD: begin
                if (bus.cache_rsp_valid) begin
                    rsp_valid_d = !(kill_q || bus.flush);
                    rsp_tag_d   = tag_q;
                    rsp_data_d  = bus.cache_rsp_data;
                    kill_d      = 1'b0;
                    state_d     = S_IDLE;
                end else if (bus.flush) begin
                    kill_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ld_ready     = w_ld_grant;
    assign bus.st_ready     = w_st_grant;
    assign bus.cache_valid  = cache_valid_q;
    assign bus.cache_write  = cache_write_q;
    assign bus.cache_addr   = cache_addr_q;
    assign bus.cache_wdata  = cache_wdata_q;
    assign bus.ld_rsp_valid = rsp_valid_q;
    assign bus.ld_rsp_tag   = rsp_tag_q;
    assign bus.ld_rsp_data  = rsp_data_q;

`ifdef DCACHE_ARB_STATS_EN
    logic [31:0] stat_ld_q;
    logic [31:0] stat_st_q;
    logic [31:0] stat_sf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ld_q <= '0;
            stat_st_q <= '0;
            stat_sf_q <= '0;
        end else begin
            if (w_ld_grant && (stat_ld_q != 32'hFFFF_FFFF)) begin
                stat_ld_q <= stat_ld_q + 32'd1;
            end
            if (w_st_grant && (stat_st_q != 32'hFFFF_FFFF)) begin
                stat_st_q <= stat_st_q + 32'd1;
            end
            // A forced load is one that beat a pending store on starvation.
            if (w_ld_grant && w_force_ld && bus.st_valid && (stat_sf_q != 32'hFFFF_FFFF)) begin
                stat_sf_q <= stat_sf_q + 32'd1;
            end
        end
    end

    assign stat_ld_grants     = stat_ld_q;
    assign stat_st_grants     = stat_st_q;
    assign stat_starve_forces = stat_sf_q;
`else
    // Statistics counters are not built in this configuration.
`endif

    a_ready_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.ld_ready && bus.st_ready));

    a_req_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (cache_valid_q && !bus.cache_ready) |=>
            (cache_valid_q && $stable(cache_addr_q) && $stable(cache_wdata_q)
             && $stable(cache_write_q)));

endmodule
`default_nettype wire
